// File: rtl/wakeup_timer_pkg.sv
// Shared constants and nibble code conversions for the wakeup timer.
package wakeup_timer_pkg;

  localparam int unsigned NIB_W = 4;

  localparam logic [3:0] BIN_TERM  = 4'hF;
  localparam logic [3:0] GRAY_TERM = 4'h8;

  function automatic logic [3:0] bin2gray4(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [3:0] gray2bin4(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    b[2] = b[3] ^ g[2];
    b[1] = b[2] ^ g[1];
    b[0] = b[1] ^ g[0];
    return b;
  endfunction

endpackage

// File: rtl/timer_nibble.sv
// One 4-bit timer stage; Gray stages count in binary internally and encode on output.
module timer_nibble
  import wakeup_timer_pkg::*;
#(
  parameter bit GRAY = 1'b0
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       cten,
  input  logic       sclr,
  input  logic       ld,
  input  logic [3:0] ld_val,
  output logic [3:0] out,
  output logic       term
);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (sclr) begin
      cnt_d = 4'h0;
    end else if (ld) begin
      cnt_d = GRAY ? gray2bin4(ld_val) : ld_val;
    end else if (cten) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt_q <= 4'h0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign out  = GRAY ? bin2gray4(cnt_q) : cnt_q;
  assign term = (out == (GRAY ? GRAY_TERM : BIN_TERM));

endmodule

// File: rtl/wakeup_timer_gc.sv
// Programmable wakeup timer: cascaded mixed Gray/binary stages, compare match,
// one-shot or auto-restart, pulse or toggle wakeup output.
module wakeup_timer_gc
  import wakeup_timer_pkg::*;
#(
  parameter int unsigned     NIB       = 5,
  parameter logic [NIB-1:0]  GRAY_MASK = 5'b00111,
  parameter int unsigned     PULSE_W   = 1
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic               en,
  input  logic               sclr,
  input  logic               ld,
  input  logic [4*NIB-1:0]   ld_val,
  input  logic [4*NIB-1:0]   cmp_val,
  input  logic               oneshot,
  input  logic               wake_mode,
  output logic [4*NIB-1:0]   out,
  output logic               wakeup,
  output logic               done,
  output logic               tc
);

  localparam logic [7:0] PLOAD = 8'(PULSE_W - 1);

  logic [NIB-1:0] term, cten;
  logic match, inc, evt, restart, wrap;
  logic done_q, done_d, tc_q, wake_q, wake_d, pact_q, pact_d;
  logic [7:0] pcnt_q, pcnt_d;

  assign match   = (out == cmp_val) & en & ~done_q;
  assign inc     = en & ~done_q & ~match & ~sclr & ~ld;
  assign evt     = match & ~sclr & ~ld;
  assign restart = evt & ~oneshot;
  assign wrap    = inc & (&term);

  for (genvar i = 0; i < NIB; i++) begin : g_stage
    // A stage advances only when every lower stage sits on its terminal code.
    if (i == 0) begin : g_first
      assign cten[i] = inc;
    end else begin : g_upper
      assign cten[i] = inc & (&term[i-1:0]);
    end

    timer_nibble #(
      .GRAY (GRAY_MASK[i])
    ) u_nib (
      .clk    (clk),
      .clr_n  (clr_n),
      .cten   (cten[i]),
      .sclr   (sclr | restart),
      .ld     (ld),
      .ld_val (ld_val[NIB_W*i +: NIB_W]),
      .out    (out[NIB_W*i +: NIB_W]),
      .term   (term[i])
    );
  end

  always_comb begin
    done_d = done_q;
    wake_d = wake_q;
    pcnt_d = pcnt_q;
    pact_d = pact_q;
    if (sclr || ld) begin
      done_d = 1'b0;
    end else if (evt && oneshot) begin
      done_d = 1'b1;
    end
    if (sclr) begin
      wake_d = 1'b0;
      pcnt_d = 8'h00;
      pact_d = 1'b0;
    end else if (evt) begin
      if (!wake_mode) begin
        wake_d = 1'b1;
        pcnt_d = PLOAD;
        pact_d = 1'b1;
      end else begin
        wake_d = ~wake_q;
        pcnt_d = 8'h00;
        pact_d = 1'b0;
      end
    end else if (pact_q) begin
      // pact_q distinguishes a timed pulse from a level held by toggle mode.
      if (pcnt_q != 8'h00) begin
        pcnt_d = pcnt_q - 8'd1;
      end else begin
        wake_d = 1'b0;
        pact_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      done_q <= 1'b0;
      tc_q   <= 1'b0;
      wake_q <= 1'b0;
      pact_q <= 1'b0;
      pcnt_q <= 8'h00;
    end else begin
      done_q <= done_d;
      tc_q   <= wrap;
      wake_q <= wake_d;
      pact_q <= pact_d;
      pcnt_q <= pcnt_d;
    end
  end

  assign wakeup = wake_q;
  assign done   = done_q;
  assign tc     = tc_q;

endmodule
